// File: rtl/hs_fir_pipe.sv
// hs_fir_pipe: pipelined direct-form FIR with sample enable, runtime-loadable
// signed coefficients, and a round/saturate output stage.
// Pipeline: S0 delay line, S1 products, S2 adder tree, S3 round/saturate.
// A sample taken on edge E appears on o_data after edge E+3.
module hs_fir_pipe #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 8,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 6
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_valid,
  input  logic signed [DATA_W-1:0]   i_data,
  input  logic                       i_coef_we,
  input  logic [$clog2(NTAPS)-1:0]   i_coef_addr,
  input  logic signed [COEF_W-1:0]   i_coef_data,
  output logic                       o_valid,
  output logic signed [OUT_W-1:0]    o_data,
  output logic                       o_sat
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS);
  // One spare bit so adding the rounding constant can never wrap.
  localparam int RND_W  = ACC_W + 1;

  localparam logic [AW:0]               NTAPS_L  = (AW+1)'(NTAPS);
  localparam logic signed [COEF_W-1:0]  COEF_ONE = COEF_W'(2**SHIFT);
  localparam logic signed [RND_W-1:0]   RND_HALF = RND_W'(2**(SHIFT-1));
  localparam logic signed [RND_W-1:0]   OUT_MAX  = RND_W'(2**(OUT_W-1) - 1);
  localparam logic signed [RND_W-1:0]   OUT_MIN  = -RND_W'(2**(OUT_W-1));

  logic signed [COEF_W-1:0] r_coef [NTAPS];
  logic signed [DATA_W-1:0] r_dly  [NTAPS];
  logic signed [PROD_W-1:0] r_prod [NTAPS];
  logic signed [ACC_W-1:0]  r_sum;
  logic                     r_v0;
  logic                     r_v1;
  logic                     r_v2;

  logic signed [ACC_W-1:0]  w_sum;
  logic signed [RND_W-1:0]  w_rnd;
  logic signed [RND_W-1:0]  w_shf;
  logic signed [OUT_W-1:0]  w_clip;
  logic                     w_sat;

  // Coefficient bank: identity at reset, out-of-range writes dropped.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_coef[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else if (i_coef_we && ({1'b0, i_coef_addr} < NTAPS_L)) begin
      r_coef[i_coef_addr] <= i_coef_data;
    end
  end

  // S0: delay line shifts only on accepted samples, so gaps insert no zeros.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_v0 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_dly[k] <= '0;
      end
    end else begin
      r_v0 <= i_valid;
      if (i_valid) begin
        r_dly[0] <= i_data;
        for (int k = 1; k < NTAPS; k++) begin
          r_dly[k] <= r_dly[k-1];
        end
      end
    end
  end

  // S1: full-precision products; reading r_coef here makes a coefficient
  // write land on the sample accepted in the same cycle but not earlier ones.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_v1 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_prod[k] <= '0;
      end
    end else begin
      r_v1 <= r_v0;
      for (int k = 0; k < NTAPS; k++) begin
        r_prod[k] <= PROD_W'(r_dly[k]) * PROD_W'(r_coef[k]);
      end
    end
  end

  // Adder tree over the sign-extended products.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      w_sum = w_sum + ACC_W'(r_prod[k]);
    end
  end

  // S2: registered sum.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_v2  <= 1'b0;
      r_sum <= '0;
    end else begin
      r_v2  <= r_v1;
      r_sum <= w_sum;
    end
  end

  // Round half up, arithmetic shift, then clip to the output range.
  always_comb begin
    w_rnd = RND_W'(r_sum) + RND_HALF;
    w_shf = w_rnd >>> SHIFT;
    w_clip = OUT_W'(w_shf);
    w_sat  = 1'b0;
    if (w_shf > OUT_MAX) begin
      w_clip = OUT_W'(OUT_MAX);
      w_sat  = 1'b1;
    end else if (w_shf < OUT_MIN) begin
      w_clip = OUT_W'(OUT_MIN);
      w_sat  = 1'b1;
    end
  end

  // S3: output register; data and sat hold while no result is presented.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= r_v2;
      if (r_v2) begin
        o_data <= w_clip;
        o_sat  <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_hs_fir_pipe.sv
// tb_hs_fir_pipe: scoreboard bench for hs_fir_pipe. Expected results come from
// a sample-history model evaluated with plain integer arithmetic.
module tb_hs_fir_pipe;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int NTAPS  = 8;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 6;
  localparam int AW     = $clog2(NTAPS);
  localparam int LAT    = 3;

  logic                      i_clk = 1'b0;
  logic                      i_reset_n = 1'b0;
  logic                      i_valid = 1'b0;
  logic signed [DATA_W-1:0]  i_data = '0;
  logic                      i_coef_we = 1'b0;
  logic [AW-1:0]             i_coef_addr = '0;
  logic signed [COEF_W-1:0]  i_coef_data = '0;
  logic                      o_valid;
  logic signed [OUT_W-1:0]   o_data;
  logic                      o_sat;

  typedef struct {
    int data;
    int sat;
    int due;
  } expT;

  expT sbQ[$];
  int  hist[$];
  int  mCoef[NTAPS];
  int  cyc = 0;
  bit  rstAtEdge = 1'b1;
  int  lastData = 0;
  int  lastSat = 0;
  int  nChecks = 0;
  int  nFails = 0;

  hs_fir_pipe #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_valid(i_valid),
    .i_data(i_data),
    .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr),
    .i_coef_data(i_coef_data),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_sat(o_sat)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  // Edge counter and whether reset was applied on that edge.
  always @(posedge i_clk) begin
    cyc       <= cyc + 1;
    rstAtEdge <= !i_reset_n;
  end

  // Reference model: identity coefficients and an empty history.
  function automatic void modelReset();
    for (int k = 0; k < NTAPS; k++) mCoef[k] = 0;
    mCoef[0] = 2**SHIFT;
    hist.delete();
  endfunction

  // Reference model: y = clip(floor((sum c[k]*x[n-k] + 2^(SHIFT-1)) / 2^SHIFT)).
  function automatic void modelPush(input int x, output int y, output int s);
    longint sum;
    longint val;
    longint q;
    longint div;
    hist.push_front(x);
    if (hist.size() > NTAPS) void'(hist.pop_back());
    sum = 0;
    for (int k = 0; k < hist.size(); k++) sum += longint'(mCoef[k]) * hist[k];
    div = longint'(2**SHIFT);
    val = sum + div / 2;
    q = val / div;
    if (val < 0 && q * div != val) q = q - 1;
    s = 0;
    if (q > 2**(OUT_W-1) - 1) begin
      q = 2**(OUT_W-1) - 1;
      s = 1;
    end else if (q < -(2**(OUT_W-1))) begin
      q = -(2**(OUT_W-1));
      s = 1;
    end
    y = int'(q);
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, update the model, and queue the expectation.
  task automatic applyStimulus(input bit v, input int d, input bit we, input int addr, input int cd);
    int y;
    int s;
    i_valid     = v;
    i_data      = DATA_W'(d);
    i_coef_we   = we;
    i_coef_addr = AW'(addr);
    i_coef_data = COEF_W'(cd);
    if (we && addr < NTAPS) mCoef[addr] = cd;
    if (v) begin
      modelPush(d, y, s);
      sbQ.push_back('{data: y, sat: s, due: cyc + 1 + LAT});
    end
    @(posedge i_clk);
    #1;
  endtask

  // Hold reset for n edges; anything due on or after the first reset edge is lost.
  task automatic doReset(input int n);
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_coef_we = 1'b0;
    modelReset();
    while (sbQ.size() > 0 && sbQ[$].due >= cyc + 1) void'(sbQ.pop_back());
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
    i_reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic writeCoef(input int addr, input int cd);
    applyStimulus(1'b0, 0, 1'b1, addr, cd);
  endtask

  // Monitor body: compare whatever the DUT presents against the scoreboard.
  task automatic checkOutput();
    expT e;
    if (rstAtEdge) begin
      compare("reset_o_valid", int'(o_valid), 0);
      compare("reset_o_data", int'(o_data), 0);
      compare("reset_o_sat", int'(o_sat), 0);
      lastData = 0;
      lastSat  = 0;
    end else if (o_valid) begin
      if (sbQ.size() == 0) begin
        compare("o_valid_spurious", int'(o_valid), 0);
      end else begin
        e = sbQ.pop_front();
        compare("output_edge", cyc, e.due);
        compare("o_data", int'(o_data), e.data);
        compare("o_sat", int'(o_sat), e.sat);
        lastData = e.data;
        lastSat  = e.sat;
      end
    end else begin
      compare("hold_o_data", int'(o_data), lastData);
      compare("hold_o_sat", int'(o_sat), lastSat);
      if (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
        compare("o_valid_due", int'(o_valid), 1);
        void'(sbQ.pop_front());
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge i_clk) checkOutput();

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d pending", sbQ.size());
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases followed by randomized traffic.
  initial begin
    modelReset();
    doReset(2);

    applyStimulus(1'b1, 5, 1'b0, 0, 0);
    applyStimulus(1'b1, 127, 1'b0, 0, 0);
    applyStimulus(1'b1, -128, 1'b0, 0, 0);
    idle(4);

    doReset(1);
    for (int k = 0; k < NTAPS; k++) writeCoef(k, k + 1);
    applyStimulus(1'b1, 64, 1'b0, 0, 0);
    for (int k = 1; k < NTAPS; k++) applyStimulus(1'b1, 0, 1'b0, 0, 0);
    idle(4);

    doReset(1);
    for (int k = 0; k < NTAPS; k++) writeCoef(k, 64);
    for (int k = 0; k < NTAPS; k++) applyStimulus(1'b1, 127, 1'b0, 0, 0);
    for (int k = 0; k < NTAPS; k++) applyStimulus(1'b1, -128, 1'b0, 0, 0);
    idle(4);

    doReset(1);
    writeCoef(0, 1);
    applyStimulus(1'b1, 32, 1'b0, 0, 0);
    applyStimulus(1'b1, 31, 1'b0, 0, 0);
    applyStimulus(1'b1, -32, 1'b0, 0, 0);
    applyStimulus(1'b1, -33, 1'b0, 0, 0);
    idle(4);

    doReset(1);
    writeCoef(0, 0);
    writeCoef(1, 64);
    applyStimulus(1'b1, 10, 1'b0, 0, 0);
    applyStimulus(1'b0, 99, 1'b0, 0, 0);
    applyStimulus(1'b0, -99, 1'b0, 0, 0);
    applyStimulus(1'b1, 20, 1'b0, 0, 0);
    applyStimulus(1'b1, 30, 1'b0, 0, 0);
    idle(4);

    doReset(1);
    applyStimulus(1'b1, 64, 1'b0, 0, 0);
    applyStimulus(1'b1, 64, 1'b1, 0, 32);
    applyStimulus(1'b1, 5, 1'b0, 0, 0);
    applyStimulus(1'b1, 6, 1'b0, 0, 0);
    doReset(1);
    applyStimulus(1'b1, 7, 1'b0, 0, 0);
    idle(4);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        doReset(1 + int'($urandom_range(0, 1)));
      end else begin
        applyStimulus($urandom_range(0, 99) < 70,
                      int'($urandom_range(0, 255)) - 128,
                      $urandom_range(0, 99) < 10,
                      int'($urandom_range(0, NTAPS - 1)),
                      int'($urandom_range(0, 255)) - 128);
      end
    end
    idle(LAT + 3);

    compare("scoreboard_drained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
